l2_req_arbiter: RTL and testbench
=================================

Name: l2_req_arbiter

Overview:
- Shares the single L2 pipe request channel (l1tol2_req) between three requesters: icache, dcache and the prefetcher.
- Tags each granted request with its source and holds it in a one-entry output register toward the L2 pipe.
- Demultiplexes the returning snack valid/retry handshake back to the originating L1 using that tag.
- Sits between the L1 caches/prefetcher and the L2 pipe, inside the L2 wrapper level.

Parameters:
- IDW, 5, width of L1 request id (dcid) from each L1.
- PW, 100, width of the request payload (cmd, pcsign, laddr, sptbr concatenated).
- PF_STARVE, 8, wait cycles after which a pending prefetch gets top priority.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- ic_req_valid  in  1  icache request valid.
- ic_req_retry  out  1  icache request not accepted this cycle.
- ic_req_dcid  in  IDW  icache request id.
- ic_req_data  in  PW  icache request payload.
- dc_req_valid  in  1  dcache request valid.
- dc_req_retry  out  1  dcache request not accepted this cycle.
- dc_req_dcid  in  IDW  dcache request id.
- dc_req_data  in  PW  dcache request payload.
- pf_req_valid  in  1  prefetch request valid.
- pf_req_retry  out  1  prefetch request not accepted this cycle.
- pf_req_data  in  PW  prefetch payload.
- l1tol2_req_valid  out  1  request to L2 pipe valid.
- l1tol2_req_retry  in  1  L2 pipe stall.
- l1tol2_req_dcid  out  IDW+2  {src[1:0], dcid}.
- l1tol2_req_data  out  PW  registered payload.
- l2tol1_snack_valid  in  1  snack from L2 pipe valid.
- l2tol1_snack_retry  out  1  back-pressure to L2 pipe.
- l2tol1_snack_dcid  in  IDW+2  tagged id.
- ic_snack_valid  out  1  snack steered to icache.
- ic_snack_retry  in  1  icache stall.
- dc_snack_valid  out  1  snack steered to dcache.
- dc_snack_retry  in  1  dcache stall.
- snack_drop_cnt  out  16  count of discarded prefetch/invalid snacks.

Behaviour:
- Handshake: a transfer occurs when valid=1 and retry=0 in the same cycle. The sender holds valid and data stable while retry=1.
- Output register state: out_v, out_dcid, out_data.
- can_load = !out_v | !l1tol2_req_retry.
- l1tol2_req_valid = out_v.
- Grant, evaluated only when can_load=1:
  - If pf_req_valid=1 and starve_cnt==PF_STARVE: grant pf.
  - Otherwise, if exactly one of ic/dc is valid: grant it.
  - Otherwise, if both ic and dc are valid: grant the one rr points to (rr=0 means ic).
  - Otherwise, if pf is valid: grant pf.
- On grant, next cycle: out_v=1, out_data=winner data, out_dcid = {2'b00, ic_dcid} for ic, {2'b01, dc_dcid} for dc, {2'b10, IDW'b0} for pf.
- If can_load=1 and there is no grant: out_v=0 next cycle.
- Grant-to-output latency is 1 cycle. Back-to-back grants are allowed every cycle while the L2 pipe does not retry.
- Requester retries: X_req_retry = !(grant to X). All three are combinational from the valids, can_load, rr and starve_cnt.
- rr update:
  - After an ic grant: rr=1.
  - After a dc grant: rr=0.
  - After a pf grant or no grant: rr unchanged.
- starve_cnt (width sized to hold PF_STARVE):
  - Cleared when pf_req_valid=0 or pf is granted.
  - Otherwise incremented while pf_req_valid=1 and not granted.
  - Saturates at PF_STARVE.
- Snack demux (combinational, zero latency); sel = l2tol1_snack_dcid[IDW+1:IDW]:
  - sel=00: ic_snack_valid = l2tol1_snack_valid; l2tol1_snack_retry = ic_snack_retry.
  - sel=01: dc_snack_valid = l2tol1_snack_valid; l2tol1_snack_retry = dc_snack_retry.
  - sel=10 or 11: no L1 valid asserted; l2tol1_snack_retry=0; snack_drop_cnt increments on each such valid snack, saturating at 16'hFFFF.
- Reset (reset=0, asynchronous), outputs and state:
  - out_v=0, rr=0, starve_cnt=0, snack_drop_cnt=0.
  - ic/dc/pf_req_retry=1 while reset is low.
  - l1tol2_req_valid=0.
  - ic/dc_snack_valid=0 and l2tol1_snack_retry=1 while reset is low.
- Reset asserted mid-operation discards any held out_v entry; requesters re-present their requests after reset.

Test Plan:
- Only ic valid, dcid=5'h03, retry=0 -> ic_req_retry=0 in cycle 0; cycle 1 l1tol2_req_valid=1, dcid=7'h03, data matches.
- ic and dc continuously valid, no L2 retry -> grants alternate ic,dc,ic,dc starting with ic after reset; dcid tags 00/01 alternate.
- L2 holds l1tol2_req_retry=1 for 4 cycles with the output full -> output stays stable; all req_retry=1; the queued winner loads on the first cycle retry=0.
- pf, ic and dc all continuously valid -> pf granted exactly on the cycle after 8 ungranted cycles; l1tol2_req_dcid=7'h40; starve_cnt back to 0.
- Snacks with sel=01 while dc_snack_retry=1 -> l2tol1_snack_retry=1; sel=10 snacks x3 -> no L1 valid, snack_drop_cnt=3.
- Assert reset while out_v=1 and ic pending -> l1tol2_req_valid=0 immediately; after release, first grant goes to ic with rr=0.

Source files
------------

// File: rtl/l2_req_arbiter.sv
// l2_req_arbiter
//   Shares the single L2 pipe request channel between icache, dcache and the
//   prefetcher. The winner is tagged with its source and held in a one-entry
//   output register toward the L2 pipe. Returning snacks are steered back to
//   the originating L1 by the same tag; prefetch/invalid snacks are dropped
//   and counted.
//
// Ports
//   clk, reset                  clock (rising edge), async active-low reset
//   ic_req_*, dc_req_*          L1 request channels (valid/retry, dcid, data)
//   pf_req_*                    prefetch request channel (valid/retry, data)
//   l1tol2_req_*                tagged request toward the L2 pipe
//   l2tol1_snack_*              snack handshake from the L2 pipe
//   ic_snack_*, dc_snack_*      snack handshake steered to each L1
//   snack_drop_cnt              saturating count of discarded snacks
module l2_req_arbiter #(
    parameter int IDW       = 5,
    parameter int PW        = 100,
    parameter int PF_STARVE = 8
) (
    input  logic           clk,
    input  logic           reset,

    input  logic           ic_req_valid,
    output logic           ic_req_retry,
    input  logic [IDW-1:0] ic_req_dcid,
    input  logic [PW-1:0]  ic_req_data,

    input  logic           dc_req_valid,
    output logic           dc_req_retry,
    input  logic [IDW-1:0] dc_req_dcid,
    input  logic [PW-1:0]  dc_req_data,

    input  logic           pf_req_valid,
    output logic           pf_req_retry,
    input  logic [PW-1:0]  pf_req_data,

    output logic           l1tol2_req_valid,
    input  logic           l1tol2_req_retry,
    output logic [IDW+1:0] l1tol2_req_dcid,
    output logic [PW-1:0]  l1tol2_req_data,

    input  logic           l2tol1_snack_valid,
    output logic           l2tol1_snack_retry,
    input  logic [IDW+1:0] l2tol1_snack_dcid,

    output logic           ic_snack_valid,
    input  logic           ic_snack_retry,
    output logic           dc_snack_valid,
    input  logic           dc_snack_retry,

    output logic [15:0]    snack_drop_cnt
);

    localparam int SCW = $clog2(PF_STARVE + 1);

    logic           r_out_v;
    logic [IDW+1:0] r_out_dcid;
    logic [PW-1:0]  r_out_data;
    logic           r_rr;          // 0: ic wins an ic/dc tie, 1: dc wins
    logic [SCW-1:0] r_starve;
    logic [15:0]    r_drop_cnt;

    logic           w_can_load;
    logic           w_pf_urgent;
    logic           w_gnt_ic;
    logic           w_gnt_dc;
    logic           w_gnt_pf;
    logic           w_any_gnt;
    logic [IDW+1:0] w_nxt_dcid;
    logic [PW-1:0]  w_nxt_data;
    logic [1:0]     w_sel;
    logic           w_drop;

    assign w_can_load  = ~r_out_v | ~l1tol2_req_retry;
    assign w_pf_urgent = pf_req_valid & (r_starve == SCW'(PF_STARVE));

    // Grants are forced off while in reset so every requester sees retry=1.
    always_comb begin
        w_gnt_ic = 1'b0;
        w_gnt_dc = 1'b0;
        w_gnt_pf = 1'b0;
        if (reset && w_can_load) begin
            if (w_pf_urgent)                    w_gnt_pf = 1'b1;
            else if (ic_req_valid && dc_req_valid) begin
                if (r_rr) w_gnt_dc = 1'b1;
                else      w_gnt_ic = 1'b1;
            end
            else if (ic_req_valid)              w_gnt_ic = 1'b1;
            else if (dc_req_valid)              w_gnt_dc = 1'b1;
            else if (pf_req_valid)              w_gnt_pf = 1'b1;
        end
    end

    assign w_any_gnt = w_gnt_ic | w_gnt_dc | w_gnt_pf;

    always_comb begin
        w_nxt_dcid = {2'b10, {IDW{1'b0}}};
        w_nxt_data = pf_req_data;
        if (w_gnt_ic) begin
            w_nxt_dcid = {2'b00, ic_req_dcid};
            w_nxt_data = ic_req_data;
        end else if (w_gnt_dc) begin
            w_nxt_dcid = {2'b01, dc_req_dcid};
            w_nxt_data = dc_req_data;
        end
    end

    assign ic_req_retry = ~w_gnt_ic;
    assign dc_req_retry = ~w_gnt_dc;
    assign pf_req_retry = ~w_gnt_pf;

    assign l1tol2_req_valid = r_out_v;
    assign l1tol2_req_dcid  = r_out_dcid;
    assign l1tol2_req_data  = r_out_data;

    // Snack demux: the top two tag bits name the source.
    assign w_sel          = l2tol1_snack_dcid[IDW+1:IDW];
    assign ic_snack_valid = reset & l2tol1_snack_valid & (w_sel == 2'b00);
    assign dc_snack_valid = reset & l2tol1_snack_valid & (w_sel == 2'b01);
    assign l2tol1_snack_retry = ~reset
                              | ((w_sel == 2'b00) & ic_snack_retry)
                              | ((w_sel == 2'b01) & dc_snack_retry);
    assign w_drop         = l2tol1_snack_valid & w_sel[1];
    assign snack_drop_cnt = r_drop_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_v    <= 1'b0;
            r_out_dcid <= '0;
            r_out_data <= '0;
            r_rr       <= 1'b0;
            r_starve   <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_can_load) begin
                r_out_v <= w_any_gnt;
                if (w_any_gnt) begin
                    r_out_dcid <= w_nxt_dcid;
                    r_out_data <= w_nxt_data;
                end
            end

            if (w_gnt_ic)      r_rr <= 1'b1;
            else if (w_gnt_dc) r_rr <= 1'b0;

            // Counts every cycle a prefetch waits, including L2 stall cycles.
            if (!pf_req_valid || w_gnt_pf)
                r_starve <= '0;
            else if (r_starve != SCW'(PF_STARVE))
                r_starve <= r_starve + SCW'(1);

            if (w_drop && (r_drop_cnt != 16'hFFFF))
                r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_l2_req_arbiter.sv
module tb_l2_req_arbiter;

    localparam int IDW       = 5;
    localparam int PW        = 100;
    localparam int PF_STARVE = 8;

    logic           clk;
    logic           reset;
    logic           ic_req_valid, ic_req_retry;
    logic [IDW-1:0] ic_req_dcid;
    logic [PW-1:0]  ic_req_data;
    logic           dc_req_valid, dc_req_retry;
    logic [IDW-1:0] dc_req_dcid;
    logic [PW-1:0]  dc_req_data;
    logic           pf_req_valid, pf_req_retry;
    logic [PW-1:0]  pf_req_data;
    logic           l1tol2_req_valid, l1tol2_req_retry;
    logic [IDW+1:0] l1tol2_req_dcid;
    logic [PW-1:0]  l1tol2_req_data;
    logic           l2tol1_snack_valid, l2tol1_snack_retry;
    logic [IDW+1:0] l2tol1_snack_dcid;
    logic           ic_snack_valid, ic_snack_retry;
    logic           dc_snack_valid, dc_snack_retry;
    logic [15:0]    snack_drop_cnt;

    l2_req_arbiter #(.IDW(IDW), .PW(PW), .PF_STARVE(PF_STARVE)) dut (
        .clk(clk), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_retry(ic_req_retry),
        .ic_req_dcid(ic_req_dcid), .ic_req_data(ic_req_data),
        .dc_req_valid(dc_req_valid), .dc_req_retry(dc_req_retry),
        .dc_req_dcid(dc_req_dcid), .dc_req_data(dc_req_data),
        .pf_req_valid(pf_req_valid), .pf_req_retry(pf_req_retry),
        .pf_req_data(pf_req_data),
        .l1tol2_req_valid(l1tol2_req_valid), .l1tol2_req_retry(l1tol2_req_retry),
        .l1tol2_req_dcid(l1tol2_req_dcid), .l1tol2_req_data(l1tol2_req_data),
        .l2tol1_snack_valid(l2tol1_snack_valid), .l2tol1_snack_retry(l2tol1_snack_retry),
        .l2tol1_snack_dcid(l2tol1_snack_dcid),
        .ic_snack_valid(ic_snack_valid), .ic_snack_retry(ic_snack_retry),
        .dc_snack_valid(dc_snack_valid), .dc_snack_retry(dc_snack_retry),
        .snack_drop_cnt(snack_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: the held output slot, the tie-break owner,
    // how long the current prefetch has waited, and the drop tally.
    bit             m_out_v;
    logic [IDW+1:0] m_out_dcid;
    logic [PW-1:0]  m_out_data;
    bit             m_rr;
    int             m_starve;
    int             m_drop;
    int             m_win;      // winner of the last cycle: -1 none, 0 ic, 1 dc, 2 pf

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] rnd_data();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[PW-1:0];
    endfunction

    task automatic model_clear();
        m_out_v    = 0;
        m_out_dcid = '0;
        m_out_data = '0;
        m_rr       = 0;
        m_starve   = 0;
        m_drop     = 0;
        m_win      = -1;
    endtask

    // Who should win this cycle, straight from the priority rules.
    function automatic int pick();
        if (!reset) return -1;
        if (m_out_v && l1tol2_req_retry) return -1;
        if (pf_req_valid && m_starve == PF_STARVE) return 2;
        if (ic_req_valid && dc_req_valid) return m_rr ? 1 : 0;
        if (ic_req_valid) return 0;
        if (dc_req_valid) return 1;
        if (pf_req_valid) return 2;
        return -1;
    endfunction

    task automatic check_now(input int w);
        logic [1:0] sel;
        logic       exp_sr;
        sel = l2tol1_snack_dcid[IDW+1:IDW];
        chk("ic_req_retry", ic_req_retry, w != 0);
        chk("dc_req_retry", dc_req_retry, w != 1);
        chk("pf_req_retry", pf_req_retry, w != 2);
        chk("out_valid", l1tol2_req_valid, m_out_v);
        if (m_out_v) begin
            chk("out_dcid", l1tol2_req_dcid, m_out_dcid);
            chk("out_data", l1tol2_req_data, m_out_data);
        end
        if (!reset)            exp_sr = 1'b1;
        else if (sel == 2'b00) exp_sr = ic_snack_retry;
        else if (sel == 2'b01) exp_sr = dc_snack_retry;
        else                   exp_sr = 1'b0;
        chk("ic_snack_valid", ic_snack_valid, reset && l2tol1_snack_valid && sel == 2'b00);
        chk("dc_snack_valid", dc_snack_valid, reset && l2tol1_snack_valid && sel == 2'b01);
        chk("snack_retry", l2tol1_snack_retry, exp_sr);
        chk("drop_cnt", snack_drop_cnt, m_drop[15:0]);
    endtask

    // One clock: check at the falling edge, advance the model past the rising edge.
    task automatic cyc();
        int             w;
        bit             n_v;
        logic [IDW+1:0] n_dcid;
        logic [PW-1:0]  n_data;
        bit             n_rr;
        int             n_starve, n_drop;
        @(negedge clk);
        w = pick();
        check_now(w);
        n_v = m_out_v; n_dcid = m_out_dcid; n_data = m_out_data;
        n_rr = m_rr; n_starve = m_starve; n_drop = m_drop;
        if (reset) begin
            if (!m_out_v || !l1tol2_req_retry) n_v = (w >= 0);
            case (w)
                0: begin n_dcid = {2'b00, ic_req_dcid}; n_data = ic_req_data; n_rr = 1; end
                1: begin n_dcid = {2'b01, dc_req_dcid}; n_data = dc_req_data; n_rr = 0; end
                2: begin n_dcid = 7'h40; n_data = pf_req_data; end
                default: ;
            endcase
            if (!pf_req_valid || w == 2) n_starve = 0;
            else if (m_starve < PF_STARVE) n_starve = m_starve + 1;
            if (l2tol1_snack_valid && l2tol1_snack_dcid[IDW+1] && m_drop < 65535)
                n_drop = m_drop + 1;
        end
        @(posedge clk);
        #1;
        if (!reset) model_clear();
        else begin
            m_out_v = n_v; m_out_dcid = n_dcid; m_out_data = n_data;
            m_rr = n_rr; m_starve = n_starve; m_drop = n_drop;
        end
        m_win = w;
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        model_clear();
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    task automatic idle_inputs();
        ic_req_valid = 0; dc_req_valid = 0; pf_req_valid = 0;
        l1tol2_req_retry = 0; l2tol1_snack_valid = 0;
        ic_snack_retry = 0; dc_snack_retry = 0;
    endtask

    initial begin
        logic [PW-1:0]  d1;
        logic [IDW+1:0] held;
        reset = 1'b0;
        ic_req_dcid = '0; dc_req_dcid = '0; l2tol1_snack_dcid = '0;
        ic_req_data = '0; dc_req_data = '0; pf_req_data = '0;
        idle_inputs();
        model_clear();

        // Reset state with requests pending.
        ic_req_valid = 1; dc_req_valid = 1; pf_req_valid = 1;
        l2tol1_snack_valid = 1;
        cyc(); cyc();
        #1;
        chk("rst_out_valid", l1tol2_req_valid, 1'b0);
        chk("rst_ic_retry", ic_req_retry, 1'b1);
        chk("rst_dc_retry", dc_req_retry, 1'b1);
        chk("rst_pf_retry", pf_req_retry, 1'b1);
        chk("rst_snack_retry", l2tol1_snack_retry, 1'b1);
        chk("rst_ic_snack_valid", ic_snack_valid, 1'b0);
        chk("rst_drop", snack_drop_cnt, 16'h0);
        idle_inputs();
        reset = 1'b1;
        cyc();

        // Single icache request.
        d1 = rnd_data();
        ic_req_valid = 1; ic_req_dcid = 5'h03; ic_req_data = d1;
        #1 chk("ic_only_retry", ic_req_retry, 1'b0);
        cyc();
        ic_req_valid = 0;
        chk("ic_only_valid", l1tol2_req_valid, 1'b1);
        chk("ic_only_dcid", l1tol2_req_dcid, 7'h03);
        chk("ic_only_data", l1tol2_req_data, d1);
        cyc();

        // Round-robin between ic and dc.
        reset_dut();
        ic_req_valid = 1; ic_req_dcid = 5'h01; ic_req_data = rnd_data();
        dc_req_valid = 1; dc_req_dcid = 5'h02; dc_req_data = rnd_data();
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("rr_alt_src", l1tol2_req_dcid[IDW+1:IDW], (i % 2 == 0) ? 2'b00 : 2'b01);
        end

        // L2 stall with the output full.
        held = m_out_dcid;
        l1tol2_req_retry = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stall_ic_retry", ic_req_retry, 1'b1);
            chk("stall_dc_retry", dc_req_retry, 1'b1);
            cyc();
            chk("stall_hold_dcid", l1tol2_req_dcid, held);
        end
        l1tol2_req_retry = 0;
        #1 chk("stall_release_ic", ic_req_retry, 1'b0);
        cyc();
        chk("stall_release_src", l1tol2_req_dcid[IDW+1:IDW], 2'b00);
        idle_inputs();
        cyc();

        // Prefetch starvation guard.
        reset_dut();
        ic_req_valid = 1; dc_req_valid = 1; pf_req_valid = 1;
        pf_req_data = rnd_data();
        for (int i = 0; i <= PF_STARVE; i++) begin
            #1 chk("pf_starve_grant", pf_req_retry, i != PF_STARVE);
            cyc();
        end
        chk("pf_dcid", l1tol2_req_dcid, 7'h40);
        chk("pf_data", l1tol2_req_data, pf_req_data);
        #1 chk("pf_starve_cleared", pf_req_retry, 1'b1);
        idle_inputs();
        cyc();

        // Snack steering and drops.
        reset_dut();
        l2tol1_snack_valid = 1; l2tol1_snack_dcid = {2'b01, 5'h04}; dc_snack_retry = 1;
        #1;
        chk("snack_dc_retry", l2tol1_snack_retry, 1'b1);
        chk("snack_dc_valid", dc_snack_valid, 1'b1);
        chk("snack_dc_no_ic", ic_snack_valid, 1'b0);
        cyc();
        dc_snack_retry = 0;
        l2tol1_snack_dcid = {2'b10, 5'h00};
        for (int i = 0; i < 3; i++) begin
            #1 chk("snack_pf_no_valid", ic_snack_valid | dc_snack_valid, 1'b0);
            cyc();
        end
        l2tol1_snack_valid = 0;
        #1 chk("snack_drop_3", snack_drop_cnt, 16'd3);
        cyc();

        // Reset while the output slot is full and ic is pending.
        ic_req_valid = 1; ic_req_dcid = 5'h0a; ic_req_data = rnd_data();
        cyc();
        l1tol2_req_retry = 1; ic_req_dcid = 5'h0b; ic_req_data = rnd_data();
        cyc();
        reset = 0;
        model_clear();
        #1 chk("midrst_out_valid", l1tol2_req_valid, 1'b0);
        cyc();
        reset = 1;
        l1tol2_req_retry = 0;
        dc_req_valid = 1; dc_req_dcid = 5'h0c; dc_req_data = rnd_data();
        #1;
        chk("midrst_ic_first", ic_req_retry, 1'b0);
        chk("midrst_dc_wait", dc_req_retry, 1'b1);
        cyc();
        chk("midrst_src", l1tol2_req_dcid, {2'b00, 5'h0b});
        idle_inputs();
        cyc();

        // Randomized traffic; requesters obey the hold-while-retried rule.
        for (int n = 0; n < 1500; n++) begin
            if (!(ic_req_valid && m_win != 0)) begin
                ic_req_valid = ($urandom_range(0, 1) == 1);
                ic_req_dcid  = IDW'($urandom);
                ic_req_data  = rnd_data();
            end
            if (!(dc_req_valid && m_win != 1)) begin
                dc_req_valid = ($urandom_range(0, 1) == 1);
                dc_req_dcid  = IDW'($urandom);
                dc_req_data  = rnd_data();
            end
            if (!(pf_req_valid && m_win != 2)) begin
                pf_req_valid = ($urandom_range(0, 2) == 0);
                pf_req_data  = rnd_data();
            end
            l1tol2_req_retry   = ($urandom_range(0, 3) == 0);
            l2tol1_snack_valid = ($urandom_range(0, 1) == 1);
            l2tol1_snack_dcid  = (IDW+2)'($urandom);
            ic_snack_retry     = ($urandom_range(0, 3) == 0);
            dc_snack_retry     = ($urandom_range(0, 3) == 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
